// File: rtl/nios_ram_loader_if.sv
// Avalon-MM bus between the RAM loader (master) and the program RAM s1 port (slave).
interface nios_ram_loader_if #(
  parameter int ADDR_W = 10
);
  logic [ADDR_W-1:0] ram_address;
  logic [3:0]        ram_byteenable;
  logic              ram_chipselect;
  logic              ram_write;
  logic [31:0]       ram_writedata;
  logic [31:0]       ram_readdata;

  modport master (
    output ram_address, ram_byteenable, ram_chipselect, ram_write, ram_writedata,
    input  ram_readdata
  );

  modport slave (
    input  ram_address, ram_byteenable, ram_chipselect, ram_write, ram_writedata,
    output ram_readdata
  );
endinterface

// File: rtl/nios_ram_loader.sv
// Fills the Nios II program RAM from a byte stream, packing little-endian words,
// then reads the region back and compares a modular checksum.
module nios_ram_loader #(
  parameter int ADDR_W = 10,
  parameter int CNT_W  = 11
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                start,
  input  logic [ADDR_W-1:0]   base_addr,
  input  logic [CNT_W-1:0]    word_count,
  input  logic [7:0]          s_data,
  input  logic                s_valid,
  output logic                s_ready,
  nios_ram_loader_if.master   ram,
  output logic                busy,
  output logic                done,
  output logic                error,
  output logic [31:0]         checksum
);

  typedef enum logic [2:0] {IDLE, FILL, WRITE, VREAD, CHECK, FINISH} state_t;

  localparam logic [CNT_W-1:0] MAX_WORDS = CNT_W'(2**ADDR_W);

  state_t            state;
  logic [ADDR_W-1:0] base_q;
  logic [CNT_W-1:0]  count_q;
  logic [CNT_W-1:0]  word_cnt;
  logic [CNT_W-1:0]  word_cnt_nxt;
  logic [1:0]        byte_cnt;
  logic [23:0]       byte_buf;
  logic [31:0]       rd_sum;
  logic [31:0]       rd_total;
  logic              rd_pend;

  assign word_cnt_nxt = word_cnt + 1'b1;
  assign rd_total     = rd_sum + ram.ram_readdata;

  // Outputs are registered, so each branch sets them for the state being entered.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state              <= IDLE;
      s_ready            <= 1'b0;
      ram.ram_address    <= '0;
      ram.ram_byteenable <= 4'h0;
      ram.ram_chipselect <= 1'b0;
      ram.ram_write      <= 1'b0;
      ram.ram_writedata  <= '0;
      busy               <= 1'b0;
      done               <= 1'b0;
      error              <= 1'b0;
      checksum           <= '0;
      base_q             <= '0;
      count_q            <= '0;
      word_cnt           <= '0;
      byte_cnt           <= '0;
      byte_buf           <= '0;
      rd_sum             <= '0;
      rd_pend            <= 1'b0;
    end else begin
      s_ready            <= 1'b0;
      ram.ram_chipselect <= 1'b0;
      ram.ram_write      <= 1'b0;
      ram.ram_byteenable <= 4'h0;
      done               <= 1'b0;

      case (state)
        IDLE: begin
          if (start) begin
            base_q   <= base_addr;
            count_q  <= word_count;
            error    <= 1'b0;
            checksum <= '0;
            byte_cnt <= '0;
            word_cnt <= '0;
            rd_sum   <= '0;
            busy     <= 1'b1;
            if (word_count == '0) begin
              state <= FINISH;
            end else if (word_count > MAX_WORDS) begin
              error <= 1'b1;
              state <= FINISH;
            end else begin
              state   <= FILL;
              s_ready <= 1'b1;
            end
          end
        end

        FILL: begin
          s_ready <= 1'b1;
          if (s_valid && s_ready) begin
            byte_cnt <= byte_cnt + 2'd1;
            case (byte_cnt)
              2'd0:    byte_buf[7:0]   <= s_data;
              2'd1:    byte_buf[15:8]  <= s_data;
              2'd2:    byte_buf[23:16] <= s_data;
              default: begin
                state              <= WRITE;
                s_ready            <= 1'b0;
                ram.ram_chipselect <= 1'b1;
                ram.ram_write      <= 1'b1;
                ram.ram_byteenable <= 4'hF;
                ram.ram_address    <= base_q + word_cnt[ADDR_W-1:0];
                ram.ram_writedata  <= {s_data, byte_buf};
              end
            endcase
          end
        end

        WRITE: begin
          checksum <= checksum + ram.ram_writedata;
          if (word_cnt_nxt == count_q) begin
            state              <= VREAD;
            word_cnt           <= '0;
            rd_pend            <= 1'b0;
            ram.ram_chipselect <= 1'b1;
            ram.ram_byteenable <= 4'hF;
            ram.ram_address    <= base_q;
          end else begin
            state    <= FILL;
            word_cnt <= word_cnt_nxt;
            s_ready  <= 1'b1;
          end
        end

        // Read data trails the address by one cycle, so the first VREAD cycle has nothing to add.
        VREAD: begin
          if (rd_pend) rd_sum <= rd_total;
          rd_pend <= 1'b1;
          if (word_cnt_nxt == count_q) begin
            state <= CHECK;
          end else begin
            word_cnt           <= word_cnt_nxt;
            ram.ram_chipselect <= 1'b1;
            ram.ram_byteenable <= 4'hF;
            ram.ram_address    <= base_q + word_cnt_nxt[ADDR_W-1:0];
          end
        end

        CHECK: begin
          rd_sum <= rd_total;
          if (rd_total != checksum) error <= 1'b1;
          state <= FINISH;
        end

        FINISH: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/nios_ram_loader.md
# nios_ram_loader

Avalon-MM master that fills the 1024×32 on-chip program RAM slave from an external byte stream (UART/JTAG receiver) before the Nios II core is released from reset. It packs bytes into little-endian words, writes them at consecutive word addresses, then reads the region back and compares a modular checksum. It sits directly upstream of the RAM's s1 port, through the system interconnect or a 2:1 master mux.

## Interface
- ADDR_W, 10, RAM word-address width; the region is 2^ADDR_W words.
- CNT_W, 11, width of `word_count`; it must hold 2^ADDR_W.

- clk  in  1  system clock; all logic is on the rising edge.
- reset_n  in  1  synchronous, active-low reset.
- start  in  1  one-cycle pulse that begins a load. Ignored while `busy`=1.
- base_addr  in  ADDR_W  first word address. Sampled on `start`.
- word_count  in  CNT_W  number of words to load. Sampled on `start`.
- s_data  in  8  stream byte.
- s_valid  in  1  `s_data` is valid.
- s_ready  out  1  loader accepts a byte this cycle.
- ram_address  out  ADDR_W  Avalon word address.
- ram_byteenable  out  4  byte enables; always 4'hF when `ram_chipselect`=1.
- ram_chipselect  out  1  Avalon chipselect.
- ram_write  out  1  Avalon write strobe.
- ram_writedata  out  32  Avalon write data.
- ram_readdata  in  32  RAM read data; valid one cycle after the address is presented.
- busy  out  1  a load is in progress.
- done  out  1  one-cycle pulse at the end of a load.
- error  out  1  sticky failure flag; cleared on an accepted `start`.
- checksum  out  32  modular sum of the words written in the last load.

## Operation
- States: IDLE, FILL, WRITE, VREAD, CHECK, FINISH.
- IDLE: `busy`=0 and `s_ready`=0. An accepted `start` latches `base_addr`/`word_count` and clears `error`, `checksum`, the byte counter and the word counter.
  - `word_count`=0: go to FINISH. No RAM access; `error` stays 0.
  - `word_count` > 2^ADDR_W: set `error`, go to FINISH. No RAM access.
  - Otherwise go to FILL.
- FILL: `s_ready`=1. Each `s_valid`&`s_ready` beat stores `s_data` into the byte lane given by the byte counter: byte 0 goes to bits [7:0], byte 3 to bits [31:24]. The 4th beat moves to WRITE. Without `s_valid`, FILL waits indefinitely.
- WRITE, one cycle:
  - `ram_chipselect`=`ram_write`=1 and `ram_byteenable`=4'hF.
  - `ram_address` = (base + word_counter) mod 2^ADDR_W; the address wraps.
  - `ram_writedata` = the packed word; `checksum` += word (mod 2^32).
  - Then increment the word counter. If it equals `word_count`, go to VREAD with the counter cleared; otherwise return to FILL.
- VREAD (pipelined):
  - Each cycle k = 0..N-1 drives `ram_chipselect`=1, `ram_write`=0, `ram_address` = base + k (wrapped).
  - A second accumulator adds `ram_readdata` on cycles k+1 = 1..N.
  - The cycle after the last address is issued, the state is CHECK. CHECK captures the final word and then compares.
- CHECK: if readback sum ≠ `checksum`, set `error`. Go to FINISH.
- FINISH: pulse `done` for one cycle, then go to IDLE.
- `busy`=1 in every state except IDLE.
- `ram_chipselect`/`ram_write` are never asserted outside WRITE/VREAD.
- The loader does not drive the RAM's clken, freeze or reset_req; the top ties those off.
- No waitrequest: the RAM slave has zero wait states.

## Timing
- Reset values: `s_ready`=0, `ram_address`=0, `ram_byteenable`=0, `ram_chipselect`=0, `ram_write`=0, `ram_writedata`=0, `busy`=0, `done`=0, `error`=0, `checksum`=0; state is IDLE.
- Reset asserted mid-load:
  - Takes effect on the next edge and aborts the load.
  - Words already written stay in the RAM; no further RAM cycles occur.
  - `done` does not pulse.
- Latency with `s_valid` held high:
  - `start` → first `s_ready`: 1 cycle.
  - Each word takes 5 cycles (4 FILL + 1 WRITE).
  - Verify takes N+1 cycles (N VREAD + CHECK), then 1 FINISH cycle.
  - `done` arrives 5N+N+3 cycles after `start`.
- Write-then-read of the same address is separated by at least one cycle, so the RAM's read-during-write "DONT_CARE" setting is never exercised.
- `start` coinciding with FINISH is ignored (`busy`=1).
- A stream byte is only consumed while `s_ready`=1. Bytes presented in other states are held off, not dropped.

## Test plan
- Reset: hold `reset_n`=0 for 3 cycles with `start`=1 → every output is at its reset value and there is no RAM cycle.
- Basic load: base=0, count=2, bytes 01 02 03 04 05 06 07 08 →
  - writes 32'h04030201 at address 0 and 32'h08070605 at address 1;
  - `checksum`=32'h0C0A0806, `error`=0;
  - `done` at cycle 15 after `start`.
- Wrap plus stalls: base=1023, count=3, `s_valid` toggling every cycle → writes at addresses 1023, 0 and 1; no lost bytes; `error`=0.
- Corruption: RAM model flips bit 0 of address 5 between WRITE and VREAD, with count=8 → `error`=1 when `done` pulses. The next `start` clears `error`.
- Boundaries:
  - count=0 → `done` 2 cycles after `start`, no RAM access, `error`=0.
  - count=1025 → `error`=1, no RAM access.
  - count=1024 → all addresses written once.
- Mid-load reset: assert `reset_n`=0 after 3 words of 8 → no further chipselect, no `done`; a subsequent load completes normally.
